// File: rtl/wired_ex_div_iter.sv
// Iterative restoring integer divider for the MDU issue path.
// Accepts one tagged div/rem request per handshake and retires 1 or 2 quotient bits per cycle.
// Divide-by-zero and signed overflow take a short fast path through FIX.
// The result is held in DONE under backpressure, and flush_i clears the unit in any state.
module wired_ex_div_iter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TAG_W          = 6,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [TAG_W-1:0] tag_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   div_q;
  logic               unsigned_q;
  logic               op_rem_q;
  logic               sign_q;
  logic               a_neg_q;
  logic               fast_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               fast_zero;
  logic               fast_ovf;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Handshake and status decode from the current state.
  always_comb begin
    ready_o = (state_q == StIdle) || ((state_q == StDone) && ready_i);
    accept  = valid_i && ready_o && !flush_i;
    valid_o = (state_q == StDone);
    busy_o  = (state_q == StCalc) || (state_q == StFix);
  end

  // Operand magnitudes and fast-path detection for an incoming request.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & a_i[WIDTH-1];
    b_neg     = is_signed & b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
    fast_zero = (b_i == '0);
    fast_ovf  = is_signed && (a_i == MinVal) && (b_i == '1);
  end

  // BITS_PER_CYCLE chained restoring steps on the (rem, quo) shift pair.
  always_comb begin
    trial    = '0;
    rem_step = rem_q;
    quo_step = quo_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      trial = {rem_step, quo_step[WIDTH-1]};
      if (trial >= {1'b0, div_q}) begin
        rem_step = WIDTH'(trial - {1'b0, div_q});
        quo_step = {quo_step[WIDTH-2:0], 1'b1};
      end else begin
        rem_step = trial[WIDTH-1:0];
        quo_step = {quo_step[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction; fast-path results are already final and bypass it.
  always_comb begin
    quo_fix = (!unsigned_q && sign_q && !fast_q) ? -quo_q : quo_q;
    rem_fix = (!unsigned_q && a_neg_q && !fast_q) ? -rem_q : rem_q;
  end

  // Control FSM and datapath registers; flush beats everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      unsigned_q <= 1'b0;
      op_rem_q   <= 1'b0;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      fast_q     <= 1'b0;
      tag_q      <= '0;
      result_q   <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else if (accept) begin
      unsigned_q <= op_i[0];
      op_rem_q   <= op_i[1];
      sign_q     <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      a_neg_q    <= a_neg;
      tag_q      <= tag_i;
      div_q      <= b_mag;
      cnt_q      <= CNT_W'(N - 1);
      if (fast_zero || fast_ovf) begin
        // Preload the final answer and let FIX pass it straight through.
        fast_q  <= 1'b1;
        quo_q   <= fast_zero ? '1 : MinVal;
        rem_q   <= fast_zero ? a_i : '0;
        state_q <= StFix;
      end else begin
        fast_q  <= 1'b0;
        quo_q   <= a_mag;
        rem_q   <= '0;
        state_q <= StCalc;
      end
    end else begin
      unique case (state_q)
        StCalc: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          result_q <= op_rem_q ? rem_fix : quo_fix;
          state_q  <= StDone;
        end
        StDone: begin
          if (ready_i) begin
            state_q <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  assign tag_o    = tag_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_wired_ex_div_iter.sv
// Directed bench for wired_ex_div_iter: one instance retiring 1 bit/cycle, one retiring 2.
module tb_wired_ex_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid1 = 1'b0;
  logic        valid2 = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [5:0]  tag_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        ready_i = 1'b1;

  logic        ready1, vo1, busy1;
  logic [5:0]  tag1;
  logic [31:0] res1;
  logic        ready2, vo2, busy2;
  logic [5:0]  tag2;
  logic [31:0] res2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wired_ex_div_iter #(.WIDTH(32), .TAG_W(6), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid1), .ready_o(ready1),
    .op_i(op_i), .tag_i(tag_i), .a_i(a_i), .b_i(b_i), .valid_o(vo1), .ready_i(ready_i),
    .tag_o(tag1), .result_o(res1), .busy_o(busy1)
  );

  wired_ex_div_iter #(.WIDTH(32), .TAG_W(6), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid2), .ready_o(ready2),
    .op_i(op_i), .tag_i(tag_i), .a_i(a_i), .b_i(b_i), .valid_o(vo2), .ready_i(ready_i),
    .tag_o(tag2), .result_o(res2), .busy_o(busy2)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one request on the chosen instance and wait (bounded) for its result.
  task automatic run_op(input logic sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag,
                        output int lat, output logic [31:0] res, output logic [5:0] tg);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; tag_i = tag;
    if (sel) valid2 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid2 = 1'b0;
    lat = 0;
    while (!(sel ? vo2 : vo1) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = sel ? res2 : res1;
    tg  = sel ? tag2 : tag1;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic [5:0]  tg;
    logic [31:0] r0;
    logic [5:0]  t0;
    logic        ok;

    vecs[0]  = '{1'b0, 2'b00, 32'd100,        32'd7,        6'd1,  32'd14,        33};
    vecs[1]  = '{1'b0, 2'b10, 32'd100,        32'd7,        6'd2,  32'd2,         33};
    vecs[2]  = '{1'b0, 2'b00, 32'hFFFFFF9C,   32'd7,        6'd3,  32'hFFFFFFF2,  33};
    vecs[3]  = '{1'b0, 2'b10, 32'hFFFFFF9C,   32'd7,        6'd4,  32'hFFFFFFFE,  33};
    vecs[4]  = '{1'b0, 2'b01, 32'hFFFFFFFF,   32'd2,        6'd5,  32'h7FFFFFFF,  33};
    vecs[5]  = '{1'b0, 2'b11, 32'hFFFFFFFF,   32'd2,        6'd6,  32'd1,         33};
    vecs[6]  = '{1'b1, 2'b01, 32'hFFFFFFFF,   32'd2,        6'd7,  32'h7FFFFFFF,  17};
    vecs[7]  = '{1'b1, 2'b11, 32'hFFFFFFFF,   32'd2,        6'd8,  32'd1,         17};
    vecs[8]  = '{1'b0, 2'b00, 32'h00001234,   32'd0,        6'd9,  32'hFFFFFFFF,  1};
    vecs[9]  = '{1'b0, 2'b10, 32'h00001234,   32'd0,        6'd10, 32'h00001234,  1};
    vecs[10] = '{1'b0, 2'b00, 32'h80000000,   32'hFFFFFFFF, 6'd11, 32'h80000000,  1};
    vecs[11] = '{1'b0, 2'b10, 32'h80000000,   32'hFFFFFFFF, 6'd12, 32'd0,         1};
    vecs[12] = '{1'b1, 2'b00, 32'd100,        32'hFFFFFFF9, 6'd13, 32'hFFFFFFF2,  17};
    vecs[13] = '{1'b1, 2'b10, 32'd100,        32'hFFFFFFF9, 6'd14, 32'd2,         17};
    vecs[14] = '{1'b0, 2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9, 6'd15, 32'd14,        33};
    vecs[15] = '{1'b0, 2'b01, 32'h80000000,   32'd3,        6'd16, 32'h2AAAAAAA,  33};
    vecs[16] = '{1'b0, 2'b11, 32'h80000000,   32'd3,        6'd17, 32'd2,         33};
    vecs[17] = '{1'b0, 2'b10, 32'hFFFFFFFB,   32'd0,        6'd18, 32'hFFFFFFFB,  1};
    vecs[18] = '{1'b1, 2'b00, 32'hFFFFFFFB,   32'd0,        6'd19, 32'hFFFFFFFF,  1};
    vecs[19] = '{1'b1, 2'b11, 32'd1000,       32'd10,       6'd20, 32'd0,         17};

    // Reset state.
    #12;
    chk("rst_valid", {31'd0, vo1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_tag", {26'd0, tag1}, 32'd0);
    chk("rst_result", res1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready1}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat, res, tg);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), {26'd0, tg}, {26'd0, vecs[i].tag});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: result held for 10 cycles, then same-cycle handover to a new request.
    @(negedge clk);
    ready_i = 1'b0;
    run_op(1'b0, 2'b00, 32'd100, 32'd7, 6'h11, lat, res, tg);
    chk("bp_first_result", res, 32'd14);
    r0 = res1;
    t0 = tag1;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (vo1 !== 1'b1 || res1 !== r0 || tag1 !== t0 || ready1 !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold_stable", {31'd0, ok}, 32'd1);
    @(negedge clk);
    ready_i = 1'b1;
    valid1 = 1'b1;
    op_i = 2'b10; a_i = 32'hFFFFFF9C; b_i = 32'd7; tag_i = 6'h22;
    #1;
    chk("bp_ready_on_handshake", {31'd0, ready1}, 32'd1);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    chk("bp_valid_drops", {31'd0, vo1}, 32'd0);
    lat = 0;
    while (!vo1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_second_latency", lat, 33);
    chk("bp_second_result", res1, 32'hFFFFFFFE);
    chk("bp_second_tag", {26'd0, tag1}, 32'h22);

    // Flush at CALC step 5 with a competing request on the same cycle.
    @(negedge clk);
    op_i = 2'b00; a_i = 32'd500; b_i = 32'd9; tag_i = 6'h05;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    valid1 = 1'b1;
    tag_i = 6'h3F;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid1 = 1'b0;
    chk("flush_ready", {31'd0, ready1}, 32'd1);
    chk("flush_busy", {31'd0, busy1}, 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (vo1) ok = 1'b1;
    end
    chk("flush_no_result", {31'd0, ok}, 32'd0);
    run_op(1'b0, 2'b00, 32'd500, 32'd9, 6'h06, lat, res, tg);
    chk("flush_fresh_result", res, 32'd55);
    chk("flush_fresh_tag", {26'd0, tg}, 32'h06);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    op_i = 2'b00; a_i = 32'd100; b_i = 32'd7; tag_i = 6'h09;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("arst_busy_before", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid_now", {31'd0, vo1}, 32'd0);
    chk("arst_busy_now", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready_after", {31'd0, ready1}, 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (vo1) ok = 1'b1;
    end
    chk("arst_no_stale", {31'd0, ok}, 32'd0);
    run_op(1'b0, 2'b10, 32'd1000, 32'd7, 6'h0A, lat, res, tg);
    chk("arst_fresh_result", res, 32'd6);
    chk("arst_fresh_latency", lat, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
